// File: rtl/mac_neuron_pkg.sv
// Shared types and helpers for the streaming MAC neuron
// and the layer blocks built around it.
package neuron_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN,
        OUT
    } neuron_state_e;

    typedef enum logic {
        ACT_IDENTITY = 1'b0,
        ACT_RELU     = 1'b1
    } act_e;

    localparam int SAT_W = 64;

    // Last DRAIN count: two flush cycles, then the result register loads.
    localparam logic [1:0] DRAIN_LAST = 2'd2;

    function automatic logic signed [SAT_W-1:0] sat_signed(
        input logic signed [SAT_W-1:0] value,
        input int unsigned             width
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (value > hi) begin
            return hi;
        end
        if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/mac_neuron_if.sv
// Control, input-stream and result handshake bundle
// between the layer controller and one neuron.
interface mac_neuron_if #(
    parameter int DATA_W = 16
) ();

    logic              start;
    logic              act_sel;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] result;
    logic              busy;

    modport master (
        output start,
        output act_sel,
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  result,
        input  busy
    );

    modport slave (
        input  start,
        input  act_sel,
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output result,
        output busy
    );

endinterface

// File: rtl/neuron_weight_rom.sv
// Synchronous-read weight ROM; the registered read is
// the first stage of the multiply-accumulate pipeline.
module neuron_weight_rom #(
  parameter int                     DEPTH = 784,
  parameter int                     WIDTH = 16,
  parameter string                  FILE  = "",
  parameter logic [DEPTH*WIDTH-1:0] INIT  = '0,
  localparam int                    AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             en,
  input  logic [AW-1:0]    addr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = INIT[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mac_neuron.sv
// Streaming fixed-point neuron: one element per beat, bias,
// rescale, identity/ReLU activation and saturation.
module mac_neuron
    import neuron_pkg::*;
#(
    parameter int                          INPUT_SIZE  = 784,
    parameter int                          DATA_W      = 16,
    parameter int                          WEIGHT_W    = 16,
    parameter int                          FRAC_BITS   = 8,
    parameter int                          ACC_W       = 42,
    parameter logic signed [DATA_W-1:0]    BIAS        = '0,
    parameter string                       WEIGHT_FILE = "weights_hidden_0.mem",
    parameter logic [INPUT_SIZE*WEIGHT_W-1:0] WEIGHT_INIT = '0
) (
    input logic         clk,
    input logic         rst_n,
    mac_neuron_if.slave bus
);

    localparam int PW    = DATA_W + WEIGHT_W;
    localparam int IDX_W = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;

    if (ACC_W < DATA_W + WEIGHT_W + $clog2(INPUT_SIZE)) begin : g_acc_chk
        $error("mac_neuron: ACC_W too narrow for INPUT_SIZE products");
    end
    if (ACC_W + FRAC_BITS + 2 > SAT_W) begin : g_sat_chk
        $error("mac_neuron: ACC_W too wide for the output stage");
    end

    neuron_state_e state_q;
    neuron_state_e state_d;

    logic [IDX_W-1:0]         idx_q;
    logic signed [ACC_W-1:0]  acc_q;
    act_e                     act_q;
    logic [1:0]               drain_q;
    logic                     v1_q;
    logic                     v2_q;
    logic signed [DATA_W-1:0] data1_q;
    logic [WEIGHT_W-1:0]      w_q;
    logic signed [PW-1:0]     prod_q;
    logic                     in_ready_q;
    logic                     out_valid_q;
    logic                     busy_q;
    logic [DATA_W-1:0]        result_q;
    logic [DATA_W-1:0]        result_d;

    logic beat;
    logic last;
    logic start_ok;
    logic drain_done;

    assign beat       = bus.in_valid & in_ready_q;
    assign last       = beat && (idx_q == IDX_W'(INPUT_SIZE - 1));
    assign start_ok   = (state_q == IDLE) && bus.start;
    assign drain_done = (state_q == DRAIN) && (drain_q == DRAIN_LAST);

    neuron_weight_rom #(
        .DEPTH (INPUT_SIZE),
        .WIDTH (WEIGHT_W),
        .FILE  (WEIGHT_FILE),
        .INIT  (WEIGHT_INIT)
    ) u_rom (
        .clk   (clk),
        .en    (beat),
        .addr  (idx_q),
        .rdata (w_q)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start)     state_d = ACCUM;
            ACCUM:   if (last)          state_d = DRAIN;
            DRAIN:   if (drain_done)    state_d = OUT;
            OUT:     if (bus.out_ready) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d == ACCUM);
            out_valid_q <= (state_d == OUT);
            busy_q      <= (state_d != IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            acc_q   <= '0;
            act_q   <= ACT_IDENTITY;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            data1_q <= '0;
            prod_q  <= '0;
        end else if (start_ok) begin
            idx_q   <= '0;
            acc_q   <= '0;
            act_q   <= act_e'(bus.act_sel);
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
        end else begin
            v1_q <= beat;
            v2_q <= v1_q;
            if (beat) begin
                idx_q   <= idx_q + 1'b1;
                data1_q <= bus.in_data;
            end
            if (v1_q) begin
                prod_q <= PW'(data1_q) * PW'($signed(w_q));
            end
            if (v2_q) begin
                acc_q <= acc_q + {{(ACC_W-PW){prod_q[PW-1]}}, prod_q};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drain_q <= '0;
        end else if (state_q == DRAIN) begin
            drain_q <= drain_q + 1'b1;
        end else begin
            drain_q <= '0;
        end
    end

    logic signed [SAT_W-1:0] bias_w;
    logic signed [SAT_W-1:0] sum_w;
    logic signed [SAT_W-1:0] shr_w;
    logic signed [SAT_W-1:0] act_w;

    always_comb begin
        bias_w = {{(SAT_W-DATA_W){BIAS[DATA_W-1]}}, BIAS};
        sum_w  = {{(SAT_W-ACC_W){acc_q[ACC_W-1]}}, acc_q}
                 + (bias_w <<< FRAC_BITS);
        shr_w  = sum_w >>> FRAC_BITS;
        act_w  = shr_w;
        if (act_q == ACT_RELU && shr_w[SAT_W-1]) begin
            act_w = '0;
        end
        result_d = DATA_W'(sat_signed(act_w, DATA_W));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
        end else if (drain_done) begin
            result_q <= result_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.result    = result_q;

endmodule

// File: tb/tb_mac_neuron.sv
// Directed bench: five neurons with different weights/bias run
// in lockstep against a transaction-level reference model.
module tb_mac_neuron;

    localparam int N  = 5;
    localparam int IS = 4;

    localparam logic signed [15:0] W_T [N] = '{
        16'sd256, 16'sd256, 16'shFF00, 16'sd32767, 16'sh8000
    };
    localparam logic signed [15:0] B_T [N] = '{
        16'sd0, 16'sd256, 16'sd0, 16'sd0, 16'sd0
    };
    localparam longint LIT_I [N] = '{2560, 2816, -2560, 32767, -32768};
    localparam longint LIT_R [N] = '{2560, 2816, 0, 32767, 0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n     = 1'b0;
    logic start     = 1'b0;
    logic act_sel   = 1'b0;
    logic in_valid  = 1'b0;
    logic out_ready = 1'b0;

    logic signed [15:0] din [N];
    logic               ir  [N];
    logic               ov  [N];
    logic               bz  [N];
    logic signed [15:0] res [N];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc++;

    for (genvar g = 0; g < N; g++) begin : g_dut
        mac_neuron_if #(.DATA_W(16)) bus ();

        assign bus.start     = start;
        assign bus.act_sel   = act_sel;
        assign bus.in_valid  = in_valid;
        assign bus.in_data   = din[g];
        assign bus.out_ready = out_ready;
        assign ir[g]         = bus.in_ready;
        assign ov[g]         = bus.out_valid;
        assign bz[g]         = bus.busy;
        assign res[g]        = bus.result;

        mac_neuron #(
            .INPUT_SIZE  (IS),
            .DATA_W      (16),
            .WEIGHT_W    (16),
            .FRAC_BITS   (8),
            .ACC_W       (42),
            .BIAS        (B_T[g]),
            .WEIGHT_FILE (""),
            .WEIGHT_INIT ({IS{W_T[g]}})
        ) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );
    end

    task automatic chk(input string nm, input int g,
                       input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %0d want %0d (cycle %0d)",
                     nm, g, act, exp, cyc);
        end
    endtask

    // Reference model: spec-level phases, beats and rounding rules.
    int     ph   = 0;
    int     lat  = 0;
    int     nacc = 0;
    logic   m_act = 1'b0;
    longint macc  [N];
    longint m_res [N];

    function automatic longint model_val(int g);
        longint v;
        v = macc[g] + (longint'(B_T[g]) <<< 8);
        v = v >>> 8;
        if (m_act && v < 0) v = 0;
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        return v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph = 0;
            lat = 0;
            nacc = 0;
            m_act = 1'b0;
            for (int g = 0; g < N; g++) begin
                macc[g] = 0;
                m_res[g] = 0;
            end
        end else begin
            case (ph)
                0: if (start) begin
                    ph = 1;
                    nacc = 0;
                    m_act = act_sel;
                    for (int g = 0; g < N; g++) macc[g] = 0;
                end
                1: if (in_valid) begin
                    for (int g = 0; g < N; g++)
                        macc[g] += longint'(din[g]) * longint'(W_T[g]);
                    nacc++;
                    if (nacc == IS) begin
                        ph = 2;
                        lat = 0;
                    end
                end
                2: begin
                    lat++;
                    if (lat == 3) begin
                        ph = 3;
                        for (int g = 0; g < N; g++) m_res[g] = model_val(g);
                    end
                end
                default: if (out_ready) ph = 0;
            endcase
        end
    end

    always @(posedge clk) begin
        #1;
        for (int g = 0; g < N; g++) begin
            chk("in_ready", g, longint'(ir[g]), longint'(ph == 1));
            chk("out_valid", g, longint'(ov[g]), longint'(ph == 3));
            chk("busy", g, longint'(bz[g]), longint'(ph != 0));
            chk("result", g, longint'(res[g]), m_res[g]);
        end
    end

    function automatic logic signed [15:0] din_of(int g, int i);
        logic signed [15:0] v [IS];
        v = '{16'sd256, 16'sd512, 16'sd768, 16'sd1024};
        return (g < 3) ? v[i] : 16'sd32767;
    endfunction

    task automatic run_inf(input logic act, input bit bub,
                           input int stall, input bit ps);
        int     i = 0;
        int     n = 0;
        int     t_last = 0;
        longint cap [N];
        @(negedge clk);
        start = 1'b1;
        act_sel = act;
        in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        while (i < IS && n < 200) begin
            in_valid = bub ? (n % 3 != 1) : 1'b1;
            for (int g = 0; g < N; g++) din[g] = din_of(g, i);
            start = ps && (i == 1);
            if (in_valid && ir[0]) begin
                if (i == IS - 1) t_last = cyc + 1;
                i++;
            end
            @(negedge clk);
            n++;
        end
        chk("beats", 0, i, IS);
        start = 1'b0;
        in_valid = 1'b1;
        for (int g = 0; g < N; g++) din[g] = 16'sd999;
        n = 0;
        while (!ov[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("out_seen", 0, longint'(ov[0]), 1);
        chk("latency", 0, cyc - t_last, 3);
        repeat (stall) begin
            start = ps;
            @(negedge clk);
        end
        out_ready = 1'b1;
        start = ps;
        for (int g = 0; g < N; g++) cap[g] = longint'(res[g]);
        @(negedge clk);
        out_ready = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        for (int g = 0; g < N; g++)
            chk("literal", g, cap[g], act ? LIT_R[g] : LIT_I[g]);
    endtask

    initial begin
        for (int g = 0; g < N; g++) din[g] = 16'sd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_inf(1'b0, 1'b0, 0, 1'b0);
        run_inf(1'b1, 1'b0, 0, 1'b0);
        run_inf(1'b0, 1'b1, 0, 1'b0);
        run_inf(1'b1, 1'b0, 10, 1'b1);

        @(negedge clk);
        start = 1'b1;
        act_sel = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            for (int g = 0; g < N; g++) din[g] = din_of(g, k);
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int g = 0; g < N; g++) begin
            chk("rst_valid", g, longint'(ov[g]), 0);
            chk("rst_ready", g, longint'(ir[g]), 0);
            chk("rst_busy", g, longint'(bz[g]), 0);
            chk("rst_result", g, longint'(res[g]), 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        run_inf(1'b0, 1'b0, 0, 1'b0);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
